// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
// Segment patterns are active-high with bit 0 = a through bit 6 = g.
package seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int IDX_W      = 3;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0    = 7'h3F;
  localparam seg7_t SEG_1    = 7'h06;
  localparam seg7_t SEG_2    = 7'h5B;
  localparam seg7_t SEG_3    = 7'h4F;
  localparam seg7_t SEG_4    = 7'h66;
  localparam seg7_t SEG_5    = 7'h6D;
  localparam seg7_t SEG_6    = 7'h7D;
  localparam seg7_t SEG_7    = 7'h07;
  localparam seg7_t SEG_8    = 7'h7F;
  localparam seg7_t SEG_9    = 7'h6F;
  localparam seg7_t SEG_DASH = 7'h40;
  localparam seg7_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg_decode.sv
// BCD nibble to active-high 7-segment pattern. Non-decimal nibbles show a
// dash so a corrupted count is visible rather than silently wrong.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg7_t      seg
);

  // Pattern lookup; a blanked digit lights nothing
  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment scanner. The BCD value and decimal points
// are captured once per frame (at the wrap from digit 5 to digit 0) so the
// number on the glass never tears mid-scan.
module seg_scan
  import seg_pkg::*;
#(
  parameter logic [31:0] SCAN_DIV       = 32'd50_000,
  parameter logic [0:0]  BLANK_LZ       = 1'b1,
  parameter logic [0:0]  SEG_ACTIVE_LOW = 1'b1,
  parameter logic [0:0]  SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] num,
  input  logic [5:0]  dp_en,
  input  logic        blank,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_DARK = SEG_ACTIVE_LOW[0] ? 8'hFF : 8'h00;
  localparam logic [5:0] SEL_DARK = SEL_ACTIVE_LOW[0] ? 6'h3F : 6'h00;

  logic [31:0]      cnt;
  logic [IDX_W-1:0] idx;
  logic [23:0]      shadow_num;
  logic [5:0]       shadow_dp;

  logic             tick;
  logic             frame_end;
  logic [3:0]       cur_nibble;
  logic             cur_dp;
  logic             cur_lz;
  logic             upper_zero;
  seg7_t            dec_seg;
  logic [7:0]       seg_act;
  logic [5:0]       sel_act;
  logic [7:0]       seg_next;
  logic [5:0]       sel_next;

  assign tick      = (cnt == SCAN_DIV - 32'd1);
  assign frame_end = tick && (idx == LAST_IDX);

  // Pick the current digit and decide whether it is a leading zero
  always_comb begin
    cur_nibble = 4'd0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (shadow_num[4*i +: 4] == 4'd0);
      if (idx == IDX_W'(i)) begin
        cur_nibble = shadow_num[4*i +: 4];
        cur_dp     = shadow_dp[i];
        cur_lz     = BLANK_LZ[0] && (i != 0) && upper_zero;
      end
    end
  end

  seg_decode u_decode (
    .nibble (cur_nibble),
    .blank  (cur_lz),
    .seg    (dec_seg)
  );

  // Build the next output word in active-high form, then apply polarity
  always_comb begin
    seg_act  = blank ? 8'h00 : {cur_dp, dec_seg};
    sel_act  = blank ? 6'h00 : (6'd1 << idx);
    seg_next = SEG_ACTIVE_LOW[0] ? ~seg_act : seg_act;
    sel_next = SEL_ACTIVE_LOW[0] ? ~sel_act : sel_act;
  end

  // Divider, digit index and once-per-frame capture of the displayed value
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_num <= '0;
      shadow_dp  <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 32'd1;
      if (tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (frame_end) begin
        shadow_num <= num;
        shadow_dp  <= dp_en;
      end
    end
  end

  // Registered pin drivers so the display lines are glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= SEL_DARK;
      seg <= SEG_DARK;
    end else begin
      sel <= sel_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with a fast divider. A behavioural model
// derives the displayed digit from the number of cycles since reset and
// the value captured at each frame start.
module tb_seg_scan;

  localparam int SD = 4;
  localparam int TRACK_LIMIT = 200;
  localparam logic [6:0] DIGIT_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk;
  logic        rst;
  logic [23:0] num;
  logic [5:0]  dp_en;
  logic        blank;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic [5:0]  sel_nolz;
  logic [7:0]  seg_nolz;

  int checks = 0;
  int passed = 0;

  // Model state
  int          cyc;
  logic [23:0] m_num;
  logic [5:0]  m_dp;
  logic [5:0]  exp_sel;
  logic [7:0]  exp_seg;
  logic [7:0]  exp_seg_nolz;
  int          m_out_d;
  bit          m_out_first;

  seg_scan #(
    .SCAN_DIV(32'd4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .num(num), .dp_en(dp_en), .blank(blank), .sel(sel), .seg(seg)
  );

  seg_scan #(
    .SCAN_DIV(32'd4), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut_nolz (
    .clk(clk), .rst(rst), .num(num), .dp_en(dp_en), .blank(blank), .sel(sel_nolz),
    .seg(seg_nolz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display word for digit d of value v, in active-low pin form
  function automatic logic [7:0] model_seg(input logic [23:0] v, input logic [5:0] dpv,
                                           input int d, input bit lz, input logic blk);
    logic [23:0] upper;
    int          nib;
    logic [6:0]  pat;
    if (blk) return 8'hFF;
    upper = v >> (4 * d);
    nib   = int'(upper % 24'd16);
    pat   = (nib > 9) ? 7'h40 : DIGIT_TBL[nib];
    if (lz && d != 0 && upper == 24'd0) pat = 7'h00;
    return ~{dpv[d], pat};
  endfunction

  // Reference: slot = cycles/SD, digit = slot mod 6, capture at each frame wrap
  always @(posedge clk) begin
    int slot;
    int d;
    if (rst) begin
      cyc = 0; m_num = '0; m_dp = '0;
      exp_sel = 6'h3F; exp_seg = 8'hFF; exp_seg_nolz = 8'hFF;
      m_out_d = 0; m_out_first = 1'b0;
    end else begin
      slot = cyc / SD;
      d    = slot % 6;
      exp_sel      = blank ? 6'h3F : ~(6'd1 << d);
      exp_seg      = model_seg(m_num, m_dp, d, 1'b1, blank);
      exp_seg_nolz = model_seg(m_num, m_dp, d, 1'b0, blank);
      m_out_d      = d;
      m_out_first  = ((cyc % SD) == 0);
      if ((cyc % SD) == SD - 1 && d == 5) begin
        m_num = num;
        m_dp  = dp_en;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance, comparing against the model every cycle, until digit d starts
  task automatic track_to_digit(input int d);
    int n = 0;
    do begin
      step();
      n++;
      checks++;
      if (sel !== exp_sel || seg !== exp_seg || sel_nolz !== exp_sel || seg_nolz !== exp_seg_nolz)
        $display("[TB] FAIL track: sel=%h seg=%h sel_nolz=%h seg_nolz=%h, required sel=%h seg=%h seg_nolz=%h",
                 sel, seg, sel_nolz, seg_nolz, exp_sel, exp_seg, exp_seg_nolz);
      else
        passed++;
    end while (!(m_out_d == d && m_out_first) && n < TRACK_LIMIT);
    if (!(m_out_d == d && m_out_first)) begin
      checks++;
      $display("[TB] FAIL track_timeout: digit %0d not reached in %0d cycles", d, TRACK_LIMIT);
    end
  endtask

  // Wait until a frame that was captured after this call is on display
  task automatic wait_frame();
    track_to_digit(5);
    track_to_digit(0);
  endtask

  task automatic test_reset();
    rst = 1'b1; num = '0; dp_en = '0; blank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sel !== 6'h3F || seg !== 8'hFF)
        $display("[TB] FAIL reset_dark: sel=%h seg=%h, required sel=3f seg=ff", sel, seg);
      else passed++;
    end
    rst = 1'b0;
    for (int i = 0; i < SD; i++) begin
      step();
      checks++;
      if (sel !== 6'h3E || seg !== 8'hC0)
        $display("[TB] FAIL first_digit0: cycle %0d sel=%h seg=%h, required sel=3e seg=c0", i, sel, seg);
      else passed++;
    end
    step();
    checks++;
    if (sel !== 6'h3D || seg !== 8'hFF)
      $display("[TB] FAIL first_tick: sel=%h seg=%h, required sel=3d seg=ff", sel, seg);
    else passed++;
  endtask

  task automatic test_lz_pattern();
    logic [7:0] want;
    num = 24'h000060; dp_en = '0;
    wait_frame();
    for (int d = 0; d < 6; d++) begin
      want = (d == 0) ? 8'hC0 : (d == 1) ? 8'h82 : 8'hFF;
      checks++;
      if (sel !== ~(6'd1 << d) || seg !== want)
        $display("[TB] FAIL lz_60 digit %0d: sel=%h seg=%h, required sel=%h seg=%h",
                 d, sel, seg, ~(6'd1 << d), want);
      else passed++;
      track_to_digit((d + 1) % 6);
    end
  endtask

  task automatic test_zero();
    num = 24'h000000;
    wait_frame();
    for (int d = 0; d < 6; d++) begin
      checks++;
      if (seg !== ((d == 0) ? 8'hC0 : 8'hFF) || seg_nolz !== 8'hC0)
        $display("[TB] FAIL zero digit %0d: seg=%h seg_nolz=%h, required seg=%h seg_nolz=c0",
                 d, seg, seg_nolz, (d == 0) ? 8'hC0 : 8'hFF);
      else passed++;
      track_to_digit((d + 1) % 6);
    end
  endtask

  task automatic test_latch_timing();
    num = 24'h000059;
    wait_frame();
    checks++;
    if (seg !== 8'h90) $display("[TB] FAIL latch_d0_9: seg=%h, required 90", seg);
    else passed++;
    track_to_digit(1);
    track_to_digit(2);
    num = 24'h000058;
    track_to_digit(3);
    track_to_digit(0);
    checks++;
    if (seg !== 8'h80) $display("[TB] FAIL latch_d0_8: seg=%h, required 80", seg);
    else passed++;
  endtask

  task automatic test_dash_dp();
    num = 24'h00000A; dp_en = 6'b000001;
    wait_frame();
    checks++;
    if (seg !== 8'h3F) $display("[TB] FAIL dash_dp: seg=%h, required 3f", seg);
    else passed++;
    dp_en = '0;
  endtask

  task automatic test_blank_pulse();
    num = 24'h123456;
    wait_frame();
    track_to_digit(3);
    blank = 1'b1;
    step();
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF)
      $display("[TB] FAIL blank_dark: sel=%h seg=%h, required sel=3f seg=ff", sel, seg);
    else passed++;
    blank = 1'b0;
    step();
    checks++;
    if (sel !== 6'h37 || seg !== 8'hB0)
      $display("[TB] FAIL blank_resume: sel=%h seg=%h, required sel=37 seg=b0", sel, seg);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    track_to_digit(4);
    rst = 1'b1;
    step();
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF)
      $display("[TB] FAIL midrst_dark: sel=%h seg=%h, required sel=3f seg=ff", sel, seg);
    else passed++;
    rst = 1'b0;
    step();
    checks++;
    if (sel !== 6'h3E || seg !== 8'hC0)
      $display("[TB] FAIL midrst_restart: sel=%h seg=%h, required sel=3e seg=c0", sel, seg);
    else passed++;
    track_to_digit(0);
  endtask

  task automatic test_random();
    logic [23:0] v;
    int          keep;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        v = 24'($urandom);
        for (int k = 0; k < 6; k++)
          if ($urandom_range(0, 3) != 0) v[4*k +: 4] = 4'($urandom_range(0, 9));
        keep = $urandom_range(1, 6);
        if (keep < 6) v = v & ((24'd1 << (4 * keep)) - 24'd1);
        num = v;
        dp_en = 6'($urandom);
      end
      blank = ($urandom_range(0, 19) == 0);
      step();
      checks++;
      if (sel !== exp_sel || seg !== exp_seg || sel_nolz !== exp_sel || seg_nolz !== exp_seg_nolz)
        $display("[TB] FAIL random cycle %0d: sel=%h seg=%h seg_nolz=%h, required sel=%h seg=%h seg_nolz=%h",
                 i, sel, seg, seg_nolz, exp_sel, exp_seg, exp_seg_nolz);
      else passed++;
    end
    blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lz_pattern();
    test_zero();
    test_latch_timing();
    test_dash_dp();
    test_blank_pulse();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
